branch_seq: RTL and testbench
=============================

BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: main control FSM requests execution of a decoded branch.
REQ-004 SHALL have port opcode, input, 6 bits: instruction opcode, sampled only with an accepted start.
REQ-005 SHALL have port cond_in, input, 1 bit: branch-taken result returned by the branch condition evaluator.
REQ-006 SHALL have port UC_control, output, 1 bit: enables the condition evaluator.
REQ-007 SHALL have port UC_op, output, 2 bits: condition select (00 BEQ, 01 BNE, 10 BLE, 11 BGT).
REQ-008 SHALL have port alu_op, output, 3 bits: 000 idle, 001 add (PC + offset<<2), 010 sub (rs - rt).
REQ-009 SHALL have port aluout_load, output, 1 bit: load ALUOut register with the branch target.
REQ-010 SHALL have port pc_write, output, 1 bit: PC write enable.
REQ-011 SHALL have port pc_src, output, 1 bit: PC source select (1 = ALUOut).
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port illegal, output, 1 bit: one-cycle pulse for a start carrying a non-branch opcode.

Function
REQ-015 SHALL implement the FSM states IDLE, TARGET, COMPARE, RESOLVE and ERR.
REQ-016 SHALL decode opcodes as: 6'h04 -> BEQ, 6'h05 -> BNE, 6'h06 -> BLE, 6'h07 -> BGT.
REQ-017 SHALL latch the decoded select into a UC_op register on an accepted start, holding it until the next accepted start.
REQ-018 IDLE: start=1 with a valid opcode -> TARGET; start=1 with an invalid opcode -> ERR; start=0 -> remain in IDLE.
REQ-019 TARGET: alu_op=001 and aluout_load=1 for exactly one cycle; then -> COMPARE.
REQ-020 COMPARE: alu_op=010 and UC_control=1 for exactly one cycle; then -> RESOLVE.
REQ-021 RESOLVE: UC_control=1 and done=1; cond_in sampled in this cycle only; transition -> IDLE.
REQ-022 RESOLVE with cond_in=1: pc_write=1 and pc_src=1 in the same cycle.
REQ-023 RESOLVE with cond_in=0: pc_write=0 and pc_src=0 (not taken; PC+4 already written by the main FSM).
REQ-024 ERR: illegal=1 and done=1 for one cycle, pc_write=0; then -> IDLE.
REQ-025 Latency: start accepted at edge k; done high during cycle k+3 (valid opcode) or cycle k+1 (ERR).
REQ-026 SHALL ignore start while busy=1, leaving both state and UC_op unchanged.
REQ-027 A start in the same cycle as done is not accepted; a new start is accepted in the first IDLE cycle.
REQ-028 All outputs other than UC_op SHALL be decoded from the state only (Moore), except pc_write/pc_src, which also depend on cond_in in RESOLVE.
REQ-029 In every state not listed above, each output SHALL be 0.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE regardless of the current state, including mid-sequence.
REQ-031 After reset, all outputs SHALL be 0, including UC_op=2'b00 and alu_op=3'b000.
REQ-032 A reset asserted in RESOLVE SHALL suppress pc_write from the following cycle onward.
REQ-033 While reset is high, start SHALL be ignored.

Configuration
REQ-034 With macro BRANCH_STATS_EN defined, the block SHALL add outputs branch_cnt[15:0] and taken_cnt[15:0].
REQ-035 With BRANCH_STATS_EN defined, branch_cnt SHALL increment once per RESOLVE cycle.
REQ-036 With BRANCH_STATS_EN defined, taken_cnt SHALL increment once per RESOLVE cycle with cond_in=1.
REQ-037 Both counters SHALL wrap from 16'hFFFF to 0 and be cleared by reset.
REQ-038 Without BRANCH_STATS_EN, the counter ports and logic SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-039 Reset then start with opcode=6'h04 and cond_in=1 in RESOLVE -> UC_op=00; TARGET/COMPARE/RESOLVE on consecutive cycles; pc_write=pc_src=done=1 in cycle k+3.
REQ-040 opcode=6'h05 with cond_in=0 -> UC_op=01, done=1 in cycle k+3, pc_write=0.
REQ-041 opcode=6'h23 -> illegal=1 and done=1 in cycle k+1; no TARGET entry; pc_write never asserted.
REQ-042 opcode=6'h07 with start held high for 6 cycles and opcode changed to 6'h04 in cycle k+1 -> UC_op stays 11; a second sequence starts only at the first IDLE cycle after done.
REQ-043 reset pulsed during COMPARE of a BLE (6'h06) -> IDLE next cycle, all outputs 0, no pc_write.
REQ-044 With BRANCH_STATS_EN, 3 taken and 2 not-taken branches -> branch_cnt=5, taken_cnt=3; preloaded to 16'hFFFF, one more branch -> branch_cnt=0.

Source files
------------

// File: rtl/branch_seq.sv
// branch_seq: branch execution sub-sequencer.
// Steps a decoded conditional branch through target computation, operand
// comparison and PC resolution, or flags a non-branch opcode as illegal.
// Optional hit/taken statistics counters are built when the macro
// BRANCH_STATS_EN is defined; without it the counter ports do not exist.
module branch_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        cond_in,
  output logic        UC_control,
  output logic [1:0]  UC_op,
  output logic [2:0]  alu_op,
  output logic        aluout_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic        busy,
  output logic        done,
  output logic        illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TARGET  = 3'd1,
    COMPARE = 3'd2,
    RESOLVE = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t     state;
  logic       resolve;
  logic       op_valid;
  logic [1:0] op_sel;

  // Map the branch opcodes onto the condition evaluator select code
  always_comb begin
    op_valid = 1'b1;
    op_sel   = 2'b00;
    case (opcode)
      6'h04:   op_sel = 2'b00;
      6'h05:   op_sel = 2'b01;
      6'h06:   op_sel = 2'b10;
      6'h07:   op_sel = 2'b11;
      default: op_valid = 1'b0;
    endcase
  end

  // Sequencer: state and the Moore outputs of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      UC_op       <= 2'b00;
      alu_op      <= ALU_IDLE;
      aluout_load <= 1'b0;
      UC_control  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      resolve     <= 1'b0;
    end else begin
      alu_op      <= ALU_IDLE;
      aluout_load <= 1'b0;
      UC_control  <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      resolve     <= 1'b0;
      busy        <= 1'b1;
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            state       <= TARGET;
            UC_op       <= op_sel;
            alu_op      <= ALU_ADD;
            aluout_load <= 1'b1;
          end else if (start) begin
            state   <= ERR;
            illegal <= 1'b1;
            done    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        TARGET: begin
          state      <= COMPARE;
          alu_op     <= ALU_SUB;
          UC_control <= 1'b1;
        end
        COMPARE: begin
          state      <= RESOLVE;
          UC_control <= 1'b1;
          done       <= 1'b1;
          resolve    <= 1'b1;
        end
        RESOLVE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A taken branch loads the PC from ALUOut during the resolve cycle
  assign pc_write = resolve & cond_in;
  assign pc_src   = resolve & cond_in;

`ifdef BRANCH_STATS_EN
  // Count resolved branches and the subset that were taken
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= 16'h0000;
      taken_cnt  <= 16'h0000;
    end else if (resolve) begin
      branch_cnt <= branch_cnt + 16'h0001;
      if (cond_in) begin
        taken_cnt <= taken_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: scoreboard bench for branch_seq with directed scenarios
// followed by randomized start/opcode/cond_in/reset traffic.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        cond_in = 1'b0;
  logic        UC_control;
  logic [1:0]  UC_op;
  logic [2:0]  alu_op;
  logic        aluout_load;
  logic        pc_write;
  logic        pc_src;
  logic        busy;
  logic        done;
  logic        illegal;
`ifdef BRANCH_STATS_EN
  logic [15:0] branch_cnt;
  logic [15:0] taken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         label;
    logic       ill;
    logic [1:0] uc;
  } exp_t;
  exp_t sb[$];

  int         edge_n     = 0;
  int         acc_edge   = 0;
  int         next_free  = 0;
  bit         acc_active = 1'b0;
  bit         acc_valid  = 1'b0;
  bit         ready      = 1'b0;
  logic [1:0] m_uc       = 2'b00;
  int         m_bc       = 0;
  int         m_tc       = 0;

  branch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .cond_in     (cond_in),
    .UC_control  (UC_control),
    .UC_op       (UC_op),
    .alu_op      (alu_op),
    .aluout_load (aluout_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] op, input logic c,
                               input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      start   = s;
      opcode  = op;
      cond_in = c;
      reset   = r;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: one branch occupies three cycles after acceptance,
  // an illegal opcode one; starts are only taken when the block is free
  initial begin
    bit v;
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        acc_active = 1'b0;
        next_free  = edge_n + 1;
        m_uc       = 2'b00;
        m_bc       = 0;
        m_tc       = 0;
        sb.delete();
        ready      = 1'b1;
      end else begin
        if (acc_active && acc_valid && (edge_n - 1 == acc_edge + 2)) begin
          m_bc++;
          if (cond_in) m_tc++;
        end
        if (start && edge_n >= next_free) begin
          v          = (opcode >= 6'h04) && (opcode <= 6'h07);
          acc_active = 1'b1;
          acc_valid  = v;
          acc_edge   = edge_n;
          if (v) begin
            m_uc      = 2'(opcode - 6'h04);
            next_free = edge_n + 4;
            sb.push_back('{label: edge_n + 2, ill: 1'b0, uc: m_uc});
          end else begin
            next_free = edge_n + 2;
            sb.push_back('{label: edge_n, ill: 1'b1, uc: m_uc});
          end
        end
      end
    end
  end

  // Monitor: compare every output each cycle and retire done events
  initial begin
    logic [12:0] ev;
    logic [12:0] av;
    logic        b, d, il, uc, ld, pw;
    logic [2:0]  al;
    int          off;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (ready) begin
        b = 0; d = 0; il = 0; uc = 0; ld = 0; pw = 0; al = 3'b000;
        if (acc_active) begin
          off = edge_n - acc_edge;
          if (!acc_valid) begin
            if (off == 0) begin b = 1; d = 1; il = 1; end
          end else begin
            case (off)
              0: begin b = 1; al = 3'b001; ld = 1; end
              1: begin b = 1; al = 3'b010; uc = 1; end
              2: begin b = 1; uc = 1; d = 1; pw = cond_in; end
              default: ;
            endcase
          end
        end
        ev = {b, d, il, uc, al, ld, pw, pw, m_uc};
        av = {busy, done, illegal, UC_control, alu_op, aluout_load, pc_write, pc_src, UC_op};
        checkOutput("outputs", 32'(av), 32'(ev));
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_cycle", edge_n, e.label);
            checkOutput("done_illegal", 32'(illegal), 32'(e.ill));
            checkOutput("done_uc_op", 32'(UC_op), 32'(e.uc));
          end
        end
`ifdef BRANCH_STATS_EN
        checkOutput("branch_cnt", 32'(branch_cnt), 32'(m_bc[15:0]));
        checkOutput("taken_cnt", 32'(taken_cnt), 32'(m_tc[15:0]));
`endif
      end
    end
  end

  // Directed scenarios followed by random traffic
  initial begin
    logic       s, c, r;
    logic [5:0] op;
    $display("[TB] starting branch_seq test");
    applyStimulus(0, 6'h00, 0, 1, 2);
    // BEQ taken
    applyStimulus(1, 6'h04, 1, 0, 1);
    applyStimulus(0, 6'h00, 1, 0, 5);
    // BNE not taken
    applyStimulus(1, 6'h05, 0, 0, 1);
    applyStimulus(0, 6'h00, 0, 0, 5);
    // illegal opcode
    applyStimulus(1, 6'h23, 1, 0, 1);
    applyStimulus(0, 6'h00, 1, 0, 3);
    // BGT with start held, opcode switched to BEQ after acceptance
    applyStimulus(1, 6'h07, 1, 0, 1);
    applyStimulus(1, 6'h04, 1, 0, 5);
    applyStimulus(0, 6'h00, 0, 0, 6);
    // BLE with reset during COMPARE
    applyStimulus(1, 6'h06, 1, 0, 1);
    applyStimulus(0, 6'h00, 1, 0, 1);
    applyStimulus(0, 6'h00, 1, 1, 1);
    applyStimulus(0, 6'h00, 1, 0, 3);
    // reset in RESOLVE, and start held during reset
    applyStimulus(1, 6'h07, 1, 0, 1);
    applyStimulus(0, 6'h00, 1, 0, 2);
    applyStimulus(1, 6'h04, 1, 1, 2);
    applyStimulus(0, 6'h00, 0, 0, 3);
    // 3 taken and 2 not-taken branches
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 6'h04 + 6'(i % 4), 1'(i < 3), 0, 1);
      applyStimulus(0, 6'h00, 1'(i < 3), 0, 3);
    end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) op = 6'(4 + $urandom_range(0, 3));
      else op = 6'($urandom_range(0, 63));
      c = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 49) == 0);
      applyStimulus(s, op, c, r, 1);
    end
    applyStimulus(0, 6'h00, 0, 0, 6);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
